ddr4_cmd_issuer: RTL and testbench

//  Upstream command stage for the emulated DIMM: takes one row/column request at a time over valid/ready
//  and drives the DDR4 command/address pins (cke, cs_n, act_n, A, bg, ba) that the DIMM model decodes.

---
 rtl/ddr4_cmd_issuer.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_ddr4_cmd_issuer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command/address issuer: one request at a time, open-page policy, counter-enforced tRP/tRCD/tCCD.
// Optional periodic refresh (PREA -> REF) is compiled in when DDR4_REFRESH_EN is defined.
module ddr4_cmd_issuer #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCCD      = 8,
    parameter int TREFI     = 1560,
    parameter int TRFC      = 52
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cas_strobe,
    output logic                 cas_we
);

    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANK  = 1 << BKW;
    localparam int TMAX_A = (TRP > TRCD) ? TRP : TRCD;
    localparam int TMAX_B = (TCCD > TRFC) ? TCCD : TRFC;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int WCW    = $clog2(TMAX) + 1;

    // Wait states hold Txx-1 cycles, so the down-counter loads Txx-2 and exits on zero.
    localparam logic [WCW-1:0] TRP_LD  = WCW'((TRP  > 1) ? TRP  - 2 : 0);
    localparam logic [WCW-1:0] TRCD_LD = WCW'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [WCW-1:0] TCCD_LD = WCW'((TCCD > 1) ? TCCD - 2 : 0);
    localparam logic [WCW-1:0] TRFC_LD = WCW'((TRFC > 1) ? TRFC - 2 : 0);

    if (ADDRWIDTH != 17 || COLWIDTH > 10 || RANKS < 1 || TRP < 1 || TRCD < 1 ||
        TCCD < 1 || TREFI < 1 || TRFC < 1) begin : g_param_check
        $error("ddr4_cmd_issuer: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_TRP_W, S_ACT, S_TRCD_W, S_CAS, S_CCD_W
`ifdef DDR4_REFRESH_EN
        , S_REF_PREA, S_REF_TRP, S_REF, S_RFC_W
`endif
    } state_e;

    typedef enum logic [2:0] {C_ACT, C_RD, C_WR, C_PRE, C_PREA, C_REF} cmd_e;

    typedef struct packed {
        logic [RANKS-1:0]     cs_n;
        logic                 act_n;
        logic [ADDRWIDTH-1:0] a;
        logic [BGWIDTH-1:0]   bg;
        logic [BAWIDTH-1:0]   ba;
        logic                 cas_strobe;
        logic                 cas_we;
    } pins_t;

    localparam pins_t PINS_RST = '{cs_n: '1, act_n: 1'b1, a: '0, bg: '0, ba: '0,
                                   cas_strobe: 1'b0, cas_we: 1'b0};

    function automatic pins_t encode(input cmd_e c, input logic [BGWIDTH-1:0] b_g,
                                     input logic [BAWIDTH-1:0] b_a,
                                     input logic [ADDRWIDTH-1:0] row,
                                     input logic [COLWIDTH-1:0] col);
        pins_t p;
        p = '{cs_n: '0, act_n: 1'b1, a: '0, bg: b_g, ba: b_a, cas_strobe: 1'b0, cas_we: 1'b0};
        case (c)
            C_ACT: begin
                p.act_n = 1'b0;
                p.a     = row;
            end
            C_RD: begin
                p.a[ADDRWIDTH-1 -: 3] = 3'b101;
                p.a[COLWIDTH-1:0]     = col;
                p.cas_strobe          = 1'b1;
            end
            C_WR: begin
                p.a[ADDRWIDTH-1 -: 3] = 3'b100;
                p.a[COLWIDTH-1:0]     = col;
                p.cas_strobe          = 1'b1;
                p.cas_we              = 1'b1;
            end
            C_PRE:  p.a[ADDRWIDTH-1 -: 3] = 3'b010;
            C_PREA: begin
                p.a[ADDRWIDTH-1 -: 3] = 3'b010;
                p.a[10]               = 1'b1;
            end
            default: p.a[ADDRWIDTH-1 -: 3] = 3'b001;
        endcase
        return p;
    endfunction

    // Deselect keeps bg/ba so the bank fields only move when a command is issued.
    function automatic pins_t deselect(input pins_t cur);
        pins_t p;
        p            = PINS_RST;
        p.bg         = cur.bg;
        p.ba         = cur.ba;
        return p;
    endfunction

    state_e               state;
    logic [WCW-1:0]       wcnt;
    pins_t                pins;
    logic                 lat_we;
    logic [BGWIDTH-1:0]   lat_bg;
    logic [BAWIDTH-1:0]   lat_ba;
    logic [ADDRWIDTH-1:0] lat_row;
    logic [COLWIDTH-1:0]  lat_col;
    logic [NBANK-1:0]     open_vld;
    logic [ADDRWIDTH-1:0] open_row [NBANK];

    logic [BKW-1:0] idx_req;
    logic [BKW-1:0] idx_lat;
    logic           row_hit;
    logic           ready_idle;
    pins_t          act_pins;
    pins_t          cas_pins;
    pins_t          pre_pins;

    assign idx_req  = {req_bg, req_ba};
    assign idx_lat  = {lat_bg, lat_ba};
    assign row_hit  = open_vld[idx_req] && (open_row[idx_req] == req_row);
    assign act_pins = encode(C_ACT, lat_bg, lat_ba, lat_row, lat_col);
    assign cas_pins = encode(lat_we ? C_WR : C_RD, lat_bg, lat_ba, lat_row, lat_col);
    assign pre_pins = encode(C_PRE, req_bg, req_ba, req_row, req_col);

`ifdef DDR4_REFRESH_EN
    localparam int RCW = $clog2(TREFI) + 1;
    logic [RCW-1:0] ref_cnt;
    logic           ref_pend;

    // Ready is withheld one cycle early so a request can never collide with the expiry edge.
    assign ready_idle = !ref_pend && (ref_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt  <= RCW'(TREFI - 1);
            ref_pend <= 1'b0;
        end else if (state == S_REF) begin
            ref_cnt  <= RCW'(TREFI - 1);
            ref_pend <= 1'b0;
        end else if (ref_cnt != '0) begin
            ref_cnt  <= ref_cnt - 1'b1;
        end else begin
            ref_pend <= 1'b1;
        end
    end
`else
    assign ready_idle = 1'b1;
`endif

    // NOTE: every state register here uses <=, so all branches see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            cke       <= 1'b0;
            req_ready <= 1'b0;
            pins      <= PINS_RST;
            open_vld  <= '0;
            lat_we    <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
        end else begin
            cke  <= 1'b1;
            pins <= deselect(pins);
            case (state)
                S_IDLE: begin
`ifdef DDR4_REFRESH_EN
                    if (ref_pend) begin
                        state     <= S_REF_PREA;
                        req_ready <= 1'b0;
                        pins      <= encode(C_PREA, pins.bg, pins.ba, '0, '0);
                    end else
`endif
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_bg    <= req_bg;
                        lat_ba    <= req_ba;
                        lat_row   <= req_row;
                        lat_col   <= req_col;
                        if (row_hit) begin
                            state <= S_CAS;
                            pins  <= encode(req_we ? C_WR : C_RD, req_bg, req_ba, req_row, req_col);
                        end else if (open_vld[idx_req]) begin
                            state <= S_PRE;
                            pins  <= pre_pins;
                        end else begin
                            state <= S_ACT;
                            pins  <= encode(C_ACT, req_bg, req_ba, req_row, req_col);
                        end
                    end else begin
                        req_ready <= ready_idle;
                    end
                end
                S_PRE: begin
                    open_vld[idx_lat] <= 1'b0;
                    if (TRP == 1) begin
                        state <= S_ACT;
                        pins  <= act_pins;
                    end else begin
                        state <= S_TRP_W;
                        wcnt  <= TRP_LD;
                    end
                end
                S_TRP_W: begin
                    if (wcnt == '0) begin
                        state <= S_ACT;
                        pins  <= act_pins;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_ACT: begin
                    open_vld[idx_lat] <= 1'b1;
                    if (TRCD == 1) begin
                        state <= S_CAS;
                        pins  <= cas_pins;
                    end else begin
                        state <= S_TRCD_W;
                        wcnt  <= TRCD_LD;
                    end
                end
                S_TRCD_W: begin
                    if (wcnt == '0) begin
                        state <= S_CAS;
                        pins  <= cas_pins;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_CAS: begin
                    if (TCCD == 1) begin
                        state     <= S_IDLE;
                        req_ready <= ready_idle;
                    end else begin
                        state <= S_CCD_W;
                        wcnt  <= TCCD_LD;
                    end
                end
                S_CCD_W: begin
                    if (wcnt == '0) begin
                        state     <= S_IDLE;
                        req_ready <= ready_idle;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
`ifdef DDR4_REFRESH_EN
                S_REF_PREA: begin
                    open_vld <= '0;
                    if (TRP == 1) begin
                        state <= S_REF;
                        pins  <= encode(C_REF, pins.bg, pins.ba, '0, '0);
                    end else begin
                        state <= S_REF_TRP;
                        wcnt  <= TRP_LD;
                    end
                end
                S_REF_TRP: begin
                    if (wcnt == '0) begin
                        state <= S_REF;
                        pins  <= encode(C_REF, pins.bg, pins.ba, '0, '0);
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_REF: begin
                    if (TRFC == 1) begin
                        state     <= S_IDLE;
                        req_ready <= ready_idle;
                    end else begin
                        state <= S_RFC_W;
                        wcnt  <= TRFC_LD;
                    end
                end
                S_RFC_W: begin
                    if (wcnt == '0) begin
                        state     <= S_IDLE;
                        req_ready <= ready_idle;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: row storage has no reset; open_vld is cleared on reset and gates every lookup.
    always_ff @(posedge clk) begin
        if (state == S_ACT) open_row[idx_lat] <= lat_row;
    end

    assign cs_n       = pins.cs_n;
    assign act_n      = pins.act_n;
    assign A          = pins.a;
    assign bg         = pins.bg;
    assign ba         = pins.ba;
    assign cas_strobe = pins.cas_strobe;
    assign cas_we     = pins.cas_we;

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Directed bench for ddr4_cmd_issuer: reset, closed-bank/hit/miss dispatch, mid-sequence reset,
// and (with DDR4_REFRESH_EN) the PREA/REF refresh sequence at TREFI=100.
module tb_ddr4_cmd_issuer;

    localparam int TRP   = 4;
    localparam int TRCD  = 4;
    localparam int TCCD  = 8;
    localparam int TREFI = 100;
    localparam int TRFC  = 52;
    localparam int NCAP  = 14;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ready;
    logic        cke;
    logic [0:0]  cs_n;
    logic        act_n;
    logic [16:0] a_bus;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        cas_strobe;
    logic        cas_we;

    ddr4_cmd_issuer #(
        .RANKS(1), .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
        .TRP(TRP), .TRCD(TRCD), .TCCD(TCCD), .TREFI(TREFI), .TRFC(TRFC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(a_bus), .bg(bg), .ba(ba),
        .cas_strobe(cas_strobe), .cas_we(cas_we)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Cycles since reset release; at the negedge after the k-th posedge cyc == k.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Pin snapshots at the i-th negedge after the accepting posedge ("@+i").
    logic [31:0] cap_cs  [1:NCAP];
    logic [31:0] cap_act [1:NCAP];
    logic [31:0] cap_a   [1:NCAP];
    logic [31:0] cap_stb [1:NCAP];
    logic [31:0] cap_we  [1:NCAP];
    logic [31:0] cap_bg  [1:NCAP];
    logic [31:0] cap_ba  [1:NCAP];
    logic [31:0] cap_rdy [1:NCAP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(tag, req_ready, 1);
    endtask

    task automatic send(input logic we, input logic [1:0] b_g, input logic [1:0] b_a,
                        input logic [16:0] row, input logic [9:0] col);
        @(negedge clk);
        wait_ready("ready_timeout");
        req_valid = 1'b1;
        req_we    = we;
        req_bg    = b_g;
        req_ba    = b_a;
        req_row   = row;
        req_col   = col;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic capture();
        for (int i = 1; i <= NCAP; i++) begin
            @(negedge clk);
            cap_cs[i]  = 32'(cs_n);
            cap_act[i] = 32'(act_n);
            cap_a[i]   = 32'(a_bus);
            cap_stb[i] = 32'(cas_strobe);
            cap_we[i]  = 32'(cas_we);
            cap_bg[i]  = 32'(bg);
            cap_ba[i]  = 32'(ba);
            cap_rdy[i] = 32'(req_ready);
        end
    endtask

    initial begin
        int strobes;
        // Reset held 5 cycles: idle pins, cke low, not ready.
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_act_n", act_n, 1);
        check("rst_cke", cke, 0);
        check("rst_ready", req_ready, 0);
        check("rst_a", a_bus, 0);
        check("rst_strobe", cas_strobe, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_cke", cke, 1);
        check("rel_ready", req_ready, 1);

`ifndef DDR4_REFRESH_EN
        // Closed bank read: ACT @+1, RD @+1+TRCD. RD: A[16:14]=101 -> 0x14000 | col.
        send(1'b0, 2'd1, 2'd2, 17'h01234, 10'h010);
        capture();
        check("rd_act_cs", cap_cs[1], 0);
        check("rd_act_n", cap_act[1], 0);
        check("rd_act_a", cap_a[1], 32'h01234);
        check("rd_act_bg", cap_bg[1], 1);
        check("rd_act_ba", cap_ba[1], 2);
        check("rd_gap_cs", cap_cs[3], 1);
        check("rd_early_stb", cap_stb[4], 0);
        check("rd_cas_cs", cap_cs[5], 0);
        check("rd_cas_act_n", cap_act[5], 1);
        check("rd_cas_a", cap_a[5], 32'h14010);
        check("rd_cas_stb", cap_stb[5], 1);
        check("rd_cas_we", cap_we[5], 0);
        check("rd_stb_pulse", cap_stb[6], 0);
        // CAS cycle plus TCCD-1 wait cycles before IDLE raises ready again.
        check("rd_ccd_busy", cap_rdy[4 + TCCD], 0);
        check("rd_ccd_ready", cap_rdy[5 + TCCD], 1);

        // Row hit write: WR @+1, A[16:14]=100 -> 0x10000 | col.
        send(1'b1, 2'd1, 2'd2, 17'h01234, 10'h020);
        capture();
        check("hit_cs", cap_cs[1], 0);
        check("hit_act_n", cap_act[1], 1);
        check("hit_a", cap_a[1], 32'h10020);
        check("hit_stb", cap_stb[1], 1);
        check("hit_we", cap_we[1], 1);

        // Row miss: PRE (A=0x08000, A10=0) @+1, ACT @+5, WR @+9.
        send(1'b1, 2'd1, 2'd2, 17'h00055, 10'h033);
        capture();
        check("miss_pre_cs", cap_cs[1], 0);
        check("miss_pre_a", cap_a[1], 32'h08000);
        check("miss_pre_stb", cap_stb[1], 0);
        check("miss_gap_cs", cap_cs[4], 1);
        check("miss_act_n", cap_act[1 + TRP], 0);
        check("miss_act_a", cap_a[1 + TRP], 32'h00055);
        check("miss_wr_a", cap_a[1 + TRP + TRCD], 32'h10033);
        check("miss_wr_stb", cap_stb[1 + TRP + TRCD], 1);
        check("miss_wr_we", cap_we[1 + TRP + TRCD], 1);

        // Table now holds 0x0055 for bg1/ba2: direct RD.
        send(1'b0, 2'd1, 2'd2, 17'h00055, 10'h007);
        capture();
        check("tbl_hit_a", cap_a[1], 32'h14007);
        check("tbl_hit_stb", cap_stb[1], 1);

        // A different, never-opened bank still needs ACT.
        send(1'b0, 2'd0, 2'd0, 17'h01234, 10'h001);
        capture();
        check("oth_act_n", cap_act[1], 0);
        check("oth_act_bg", cap_bg[1], 0);

        // Reset while in TRCD wait: pins go idle at once, no CAS ever appears.
        send(1'b0, 2'd3, 2'd1, 17'h01abc, 10'h005);
        @(negedge clk);
        check("rtw_act_n", act_n, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rtw_cs_n", cs_n, 1);
        check("rtw_act_idle", act_n, 1);
        check("rtw_cke", cke, 0);
        check("rtw_ready", req_ready, 0);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            strobes += int'(cas_strobe);
        end
        check("rtw_no_cas", strobes, 0);
        reset_n = 1'b1;
        send(1'b0, 2'd3, 2'd1, 17'h01abc, 10'h005);
        capture();
        check("rtw_re_act_n", cap_act[1], 0);
        check("rtw_re_act_a", cap_a[1], 32'h01abc);
        check("rtw_re_cas_a", cap_a[1 + TRCD], 32'h14005);
`else
        // Open a row, then let TREFI expire while idle.
        send(1'b0, 2'd1, 2'd2, 17'h00055, 10'h001);
        capture();
        check("ref_pre_act_n", cap_act[1], 0);
        wait_ready("ref_ready_timeout");
        begin
            int n = 0;
            while (req_ready === 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) check("ref_drop_timeout", req_ready, 0);
        end
        check("ref_expiry_cycle", cyc, TREFI);
        @(negedge clk);
        check("ref_prea_cs", cs_n, 0);
        check("ref_prea_act_n", act_n, 1);
        check("ref_prea_a", a_bus, 32'h08400);
        repeat (TRP - 1) @(negedge clk);
        check("ref_trp_cs", cs_n, 1);
        @(negedge clk);
        check("ref_ref_cs", cs_n, 0);
        check("ref_ref_a", a_bus, 32'h04000);
        check("ref_ready_low", req_ready, 0);
        // All banks closed by PREA: the same row now needs ACT.
        send(1'b0, 2'd1, 2'd2, 17'h00055, 10'h001);
        capture();
        check("ref_post_act_n", cap_act[1], 0);
        check("ref_post_act_a", cap_a[1], 32'h00055);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
